testing_wb_master: RTL and testbench

TESTING_WB_MASTER -- requirements
Module: testing_wb_master

---
 rtl/testing_wb_master.sv | 193 +++++++++++++++++++
 tb/tb_testing_wb_master.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/testing_wb_master.sv
// Single-transfer Wishbone classic master driven by a simple command port.
// Retries on rty with a one-cycle backoff, and gives up after a bus-phase timeout.
module testing_wb_master #(
    parameter int dw        = 32,
    parameter int aw        = 32,
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 3
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,
    input  logic          cmd_start_i,
    input  logic          cmd_we_i,
    input  logic [aw-1:0] cmd_adr_i,
    input  logic [dw-1:0] cmd_dat_i,
    input  logic [3:0]    cmd_sel_i,
    output logic          cmd_busy_o,
    output logic          cmd_done_o,
    output logic [dw-1:0] cmd_rdata_o,
    output logic [1:0]    cmd_status_o,
    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    input  logic [dw-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i
);

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERR     = 2'b01;
    localparam logic [1:0] ST_RETRY   = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_BACKOFF, S_DONE} state_t;

    state_t        state_reg, state_next;
    logic [aw-1:0] adr_reg, adr_next;
    logic [dw-1:0] dat_reg, dat_next;
    logic [3:0]    sel_reg, sel_next;
    logic          we_reg, we_next;
    logic          cyc_reg, cyc_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic [dw-1:0] rdata_reg, rdata_next;
    logic [1:0]    status_reg, status_next;
    logic [TW-1:0] tmo_reg, tmo_next;
    logic [RW-1:0] retry_reg, retry_next;

    logic retry_left;
    logic tmo_hit;

    assign retry_left = (retry_reg < RW'(MAX_RETRY));
    assign tmo_hit    = (tmo_reg == TW'(TIMEOUT));

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (cmd_start_i) state_next = S_BUS;
            end
            S_BUS: begin
                if (wb_err_i)      state_next = S_DONE;
                else if (wb_rty_i) state_next = retry_left ? S_BACKOFF : S_DONE;
                else if (wb_ack_i) state_next = S_DONE;
                else if (tmo_hit)  state_next = S_DONE;
            end
            S_BACKOFF: state_next = S_BUS;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Next values for every registered output; responses only matter in BUS.
    always_comb begin
        adr_next    = adr_reg;
        dat_next    = dat_reg;
        sel_next    = sel_reg;
        we_next     = we_reg;
        cyc_next    = cyc_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        rdata_next  = rdata_reg;
        status_next = status_reg;
        tmo_next    = tmo_reg;
        retry_next  = retry_reg;
        case (state_reg)
            S_IDLE: begin
                if (cmd_start_i) begin
                    adr_next   = cmd_adr_i;
                    dat_next   = cmd_dat_i;
                    sel_next   = cmd_sel_i;
                    we_next    = cmd_we_i;
                    cyc_next   = 1'b1;
                    busy_next  = 1'b1;
                    tmo_next   = '0;
                    retry_next = '0;
                end
            end
            S_BUS: begin
                if (wb_err_i) begin
                    cyc_next    = 1'b0;
                    busy_next   = 1'b0;
                    done_next   = 1'b1;
                    status_next = ST_ERR;
                end else if (wb_rty_i) begin
                    cyc_next = 1'b0;
                    if (retry_left) begin
                        retry_next = retry_reg + RW'(1);
                        tmo_next   = '0;
                    end else begin
                        busy_next   = 1'b0;
                        done_next   = 1'b1;
                        status_next = ST_RETRY;
                    end
                end else if (wb_ack_i) begin
                    cyc_next    = 1'b0;
                    busy_next   = 1'b0;
                    done_next   = 1'b1;
                    status_next = ST_OK;
                    if (!we_reg) rdata_next = wb_dat_i;
                end else if (tmo_hit) begin
                    cyc_next    = 1'b0;
                    busy_next   = 1'b0;
                    done_next   = 1'b1;
                    status_next = ST_TIMEOUT;
                end else begin
                    tmo_next = tmo_reg + TW'(1);
                end
            end
            S_BACKOFF: cyc_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            adr_reg    <= '0;
            dat_reg    <= '0;
            sel_reg    <= '0;
            we_reg     <= 1'b0;
            cyc_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            rdata_reg  <= '0;
            status_reg <= ST_OK;
            tmo_reg    <= '0;
            retry_reg  <= '0;
        end else begin
            adr_reg    <= adr_next;
            dat_reg    <= dat_next;
            sel_reg    <= sel_next;
            we_reg     <= we_next;
            cyc_reg    <= cyc_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            rdata_reg  <= rdata_next;
            status_reg <= status_next;
            tmo_reg    <= tmo_next;
            retry_reg  <= retry_next;
        end
    end

    // stb always tracks cyc: classic single transfers only.
    assign wb_adr_o     = adr_reg;
    assign wb_dat_o     = dat_reg;
    assign wb_sel_o     = sel_reg;
    assign wb_we_o      = we_reg;
    assign wb_cyc_o     = cyc_reg;
    assign wb_stb_o     = cyc_reg;
    assign wb_cti_o     = 3'b000;
    assign wb_bte_o     = 2'b00;
    assign cmd_busy_o   = busy_reg;
    assign cmd_done_o   = done_reg;
    assign cmd_rdata_o  = rdata_reg;
    assign cmd_status_o = status_reg;

endmodule

// File: tb/tb_testing_wb_master.sv
// Randomized bench for testing_wb_master: scripted registered-response slave,
// transaction-level reference model (memory, status, attempt and cycle counts).
module tb_testing_wb_master;

    localparam int TMO  = 8;
    localparam int MAXR = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        cmd_busy, cmd_done;
    logic [31:0] cmd_rdata;
    logic [1:0]  cmd_status;
    logic [31:0] wb_adr, wb_dat_o;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [31:0] s_dat;
    logic        s_ack, s_err, s_rty;

    always #5 clk = ~clk;

    testing_wb_master #(.dw(32), .aw(32), .TIMEOUT(TMO), .MAX_RETRY(MAXR)) dut (
        .wb_clk(clk), .wb_rst_n(rst_n),
        .cmd_start_i(cmd_start), .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr),
        .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .cmd_busy_o(cmd_busy), .cmd_done_o(cmd_done),
        .cmd_rdata_o(cmd_rdata), .cmd_status_o(cmd_status),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_cti_o(wb_cti), .wb_bte_o(wb_bte),
        .wb_dat_i(s_dat), .wb_ack_i(s_ack), .wb_err_i(s_err), .wb_rty_i(s_rty)
    );

    // Slave script: cfg_rty retries, then final response (0 ack, 1 err, 2 err+ack, 3 silent).
    int          cfg_rty = 0;
    int          cfg_mode = 0;
    int          rty_given;
    logic [31:0] smem [16];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ack <= 1'b0; s_err <= 1'b0; s_rty <= 1'b0; s_dat <= '0;
            rty_given <= 0;
            for (int i = 0; i < 16; i++) smem[i] <= '0;
        end else begin
            s_ack <= 1'b0; s_err <= 1'b0; s_rty <= 1'b0;
            if (!cmd_busy) rty_given <= 0;
            if (wb_cyc && wb_stb && !s_ack && !s_err && !s_rty) begin
                if (rty_given < cfg_rty) begin
                    s_rty <= 1'b1;
                    rty_given <= rty_given + 1;
                end else begin
                    case (cfg_mode)
                        0: begin
                            s_ack <= 1'b1;
                            if (wb_we) begin
                                for (int b = 0; b < 4; b++)
                                    if (wb_sel[b]) smem[wb_adr[5:2]][8*b +: 8] <= wb_dat_o[8*b +: 8];
                            end else begin
                                s_dat <= smem[wb_adr[5:2]];
                            end
                        end
                        1: s_err <= 1'b1;
                        2: begin s_err <= 1'b1; s_ack <= 1'b1; end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Bus monitor: cumulative counters, diffed per transaction.
    int          n_cyc = 0, n_stb = 0, n_gap = 0, n_done = 0, n_bad = 0;
    logic        stb_q = 1'b0;
    logic        cur_we = 1'b0;
    logic [31:0] cur_adr = '0, cur_dat = '0;
    logic [3:0]  cur_sel = '0;

    always @(negedge clk) begin
        if (wb_cyc) n_cyc++;
        if (wb_stb && !stb_q) n_stb++;
        stb_q = wb_stb;
        if (cmd_busy && !wb_cyc) n_gap++;
        if (cmd_done) n_done++;
        if (wb_cyc != wb_stb || wb_cti != 3'b000 || wb_bte != 2'b00) n_bad++;
        if (wb_stb && (wb_adr != cur_adr || wb_sel != cur_sel || wb_we != cur_we ||
                       (cur_we && wb_dat_o != cur_dat))) n_bad++;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [31:0] ref_mem [16];
    logic [31:0] exp_rdata = '0;
    int          txn_no = 0;

    task automatic run_txn(input logic we, input int idx, input logic [31:0] dat,
                           input logic [3:0] sel, input int nrty, input int mode,
                           input bit poke);
        int s_cyc, s_stb, s_gap, s_done, s_bad;
        int attempts, e_cyc;
        logic [1:0] e_status;
        bit got;
        s_cyc = n_cyc; s_stb = n_stb; s_gap = n_gap; s_done = n_done; s_bad = n_bad;
        cfg_rty = nrty; cfg_mode = mode;
        cur_we = we; cur_adr = 32'(idx) << 2; cur_dat = dat; cur_sel = sel;

        if (nrty > MAXR) begin
            attempts = MAXR + 1;
            e_status = 2'b10;
            e_cyc    = 2 * attempts;
        end else begin
            attempts = nrty + 1;
            case (mode)
                0:       e_status = 2'b00;
                1, 2:    e_status = 2'b01;
                default: e_status = 2'b11;
            endcase
            e_cyc = 2 * nrty + ((mode == 3) ? TMO + 1 : 2);
        end
        if (e_status == 2'b00) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
            end else begin
                exp_rdata = ref_mem[idx];
            end
        end

        @(negedge clk);
        cmd_start = 1'b1; cmd_we = we; cmd_adr = cur_adr; cmd_dat = dat; cmd_sel = sel;
        @(posedge clk); #1;
        cmd_we = 1'($urandom); cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
        if (poke) begin
            @(posedge clk); #1;
        end
        cmd_start = 1'b0;

        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_done) begin got = 1'b1; break; end
        end
        check_val("done_seen", 64'(got), 64'd1);
        if (got) begin
            check_val("status", 64'(cmd_status), 64'(e_status));
            check_val("rdata", 64'(cmd_rdata), 64'(exp_rdata));
            check_val("busy_at_done", 64'(cmd_busy), 64'd0);
        end
        @(posedge clk); #1;
        check_val("done_width", 64'(cmd_done), 64'd0);
        check_val("stb_count", 64'(n_stb - s_stb), 64'(attempts));
        check_val("backoff_gaps", 64'(n_gap - s_gap), 64'(attempts - 1));
        check_val("cyc_cycles", 64'(n_cyc - s_cyc), 64'(e_cyc));
        check_val("done_pulses", 64'(n_done - s_done), 64'd1);
        check_val("bus_fields", 64'(n_bad - s_bad), 64'd0);
        $display("txn %0d: we=%0b adr=%0h dat=%08h sel=%0h rty=%0d mode=%0d -> status=%0b rdata=%08h",
                 txn_no, we, cur_adr, dat, sel, nrty, mode, cmd_status, cmd_rdata);
        txn_no++;
    endtask

    task automatic reset_mid_bus();
        int s_done;
        cfg_rty = 0; cfg_mode = 3;
        cur_we = 1'b0; cur_adr = 32'h1c; cur_sel = 4'hF; cur_dat = '0;
        @(negedge clk);
        cmd_start = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h1c; cmd_sel = 4'hF;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_val("busy_before_rst", 64'(wb_cyc & cmd_busy), 64'd1);
        s_done = n_done;
        rst_n = 1'b0;
        #1;
        check_val("rst_cyc", 64'(wb_cyc), 64'd0);
        check_val("rst_stb", 64'(wb_stb), 64'd0);
        check_val("rst_busy", 64'(cmd_busy), 64'd0);
        check_val("rst_status", 64'(cmd_status), 64'd0);
        check_val("rst_rdata", 64'(cmd_rdata), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_no_done", 64'(n_done - s_done), 64'd0);
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        exp_rdata = '0;
        $display("txn %0d: reset asserted during bus phase", txn_no);
        txn_no++;
    endtask

    initial begin
        int idx, mode, nrty;
        logic [31:0] d;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        repeat (3) @(negedge clk);
        check_val("reset_cyc", 64'(wb_cyc), 64'd0);
        check_val("reset_stb", 64'(wb_stb), 64'd0);
        check_val("reset_busy", 64'(cmd_busy), 64'd0);
        check_val("reset_done", 64'(cmd_done), 64'd0);
        check_val("reset_adr", 64'(wb_adr), 64'd0);
        check_val("reset_sel", 64'(wb_sel), 64'd0);
        check_val("reset_status", 64'(cmd_status), 64'd0);
        rst_n = 1'b1;

        run_txn(1'b1, 1, 32'hDEADBEEF, 4'hF, 0, 0, 1'b0);
        run_txn(1'b0, 1, 32'h0, 4'hF, 0, 0, 1'b0);
        check_val("read_deadbeef", 64'(cmd_rdata), 64'h0000_0000_DEAD_BEEF);
        run_txn(1'b1, 2, 32'hFFFFFFFF, 4'hF, 0, 0, 1'b0);
        run_txn(1'b1, 2, 32'h12345678, 4'b0011, 0, 0, 1'b0);
        run_txn(1'b0, 2, 32'h0, 4'hF, 0, 0, 1'b0);
        check_val("read_merged", 64'(cmd_rdata), 64'h0000_0000_FFFF_5678);
        run_txn(1'b0, 1, 32'h0, 4'hF, 2, 0, 1'b0);
        run_txn(1'b1, 3, 32'hA5A5A5A5, 4'hF, 4, 0, 1'b0);
        run_txn(1'b0, 3, 32'h0, 4'hF, 0, 3, 1'b0);
        run_txn(1'b0, 1, 32'h0, 4'hF, 0, 2, 1'b0);
        run_txn(1'b1, 4, 32'h0BADF00D, 4'hF, 0, 1, 1'b0);
        run_txn(1'b1, 5, 32'hCAFEF00D, 4'hF, 0, 0, 1'b1);
        run_txn(1'b0, 5, 32'h0, 4'hF, 1, 0, 1'b1);
        reset_mid_bus();
        run_txn(1'b0, 1, 32'h0, 4'hF, 0, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            idx  = int'($urandom_range(0, 15));
            d    = $urandom;
            mode = int'($urandom_range(0, 9));
            mode = (mode < 6 || mode == 9) ? 0 : mode - 5;
            nrty = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_txn(1'($urandom), idx, d, 4'($urandom), nrty, mode, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
